// File: rtl/write_back_arbiter.sv
// Round-robin arbiter sharing one registered write-back port among NUM_REQ requesters, with locked bursts.
// Latency: one cycle from an accepted beat to wb_en/wb_addr/wb_data/wb_src.
// Backpressure: wb_stall or a held lock withholds req_ready; waiting requesters keep req_valid high.
module write_back_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = 5,
    parameter  int DATA_W  = 32,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_stall,
    output logic                      wb_en,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic [SRC_W-1:0]          wb_src
);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [SRC_W-1:0] ptr, ptr_n;
    logic [SRC_W-1:0] owner, owner_n;
    logic             grant_vld;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] scan_idx;
    logic             xfer;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] data_sel;

    // Candidate selection looks only at req_valid, so req_lock never reaches req_ready.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (state == LOCKED) begin
            grant_vld = req_valid[owner];
            grant_idx = owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_idx = SRC_W'((int'(ptr) + k) % NUM_REQ);
                if (!grant_vld && req_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    assign xfer = grant_vld && !wb_stall && rst_n;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        addr_sel = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        data_sel = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        if (xfer) begin
            if (req_lock[grant_idx]) begin
                state_n = LOCKED;
                owner_n = grant_idx;
            end else begin
                state_n = ARB;
                ptr_n   = SRC_W'((int'(grant_idx) + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
        end
    end

    // Address, data and source hold across idle cycles; only wb_en drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            wb_src  <= '0;
        end else begin
            wb_en <= xfer;
            if (xfer) begin
                wb_addr <= addr_sel;
                wb_data <= data_sel;
                wb_src  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_write_back_arbiter.sv
// Directed and random checks of write_back_arbiter against a transaction-level reference model.
module tb_write_back_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wb_stall;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [1:0]      wb_src;

    logic [AW-1:0] a_arr [N];
    logic [DW-1:0] d_arr [N];

    int tests = 0;
    int fails = 0;

    // reference model: ownership flag, owner, rotating pointer, expected outputs
    bit            m_locked;
    int            m_owner;
    int            m_ptr;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_src;
    logic [N-1:0]  obs_ready;

    write_back_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .wb_stall(wb_stall), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_src(wb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a_arr[i];
            req_data[i*DW +: DW] = d_arr[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0;
        m_en = 0; m_addr = '0; m_data = '0; m_src = 0;
    endfunction

    // Who is accepted this cycle according to the rules; -1 when nobody.
    function automatic int model_grant();
        int order [$];
        if (!rst_n || wb_stall) return -1;
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[k]) if (req_valid[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic tick(output int g);
        logic [N-1:0] one;
        logic [N-1:0] exp_ready;
        bit            n_locked;
        int            n_owner, n_ptr, n_src;
        logic          n_en;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_data;
        @(negedge clk);
        g = model_grant();
        one = 1;
        exp_ready = (g >= 0) ? (one << g) : '0;
        obs_ready = req_ready;
        check("ready", {60'd0, req_ready}, {60'd0, exp_ready});
        check("wb_en", {63'd0, wb_en}, {63'd0, m_en});
        check("wb_addr", {59'd0, wb_addr}, {59'd0, m_addr});
        check("wb_data", {32'd0, wb_data}, {32'd0, m_data});
        check("wb_src", {62'd0, wb_src}, 64'(m_src));
        n_locked = m_locked; n_owner = m_owner; n_ptr = m_ptr;
        n_addr = m_addr; n_data = m_data; n_src = m_src;
        n_en = (g >= 0);
        if (g >= 0) begin
            n_addr = a_arr[g]; n_data = d_arr[g]; n_src = g;
            if (req_lock[g]) begin
                n_locked = 1; n_owner = g;
            end else begin
                n_locked = 0; n_ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else begin
            m_locked = n_locked; m_owner = n_owner; m_ptr = n_ptr;
            m_en = n_en; m_addr = n_addr; m_data = n_data; m_src = n_src;
        end
    endtask

    task automatic expect_grant(input string tag, input int idx);
        logic [N-1:0] one;
        one = 1;
        check(tag, {60'd0, obs_ready}, {60'd0, one << idx});
        check({tag, "_src"}, {62'd0, wb_src}, 64'(idx));
        check({tag, "_data"}, {32'd0, wb_data}, {32'd0, d_arr[idx]});
    endtask

    initial begin
        int g;
        logic [N-1:0] pend;
        model_reset();
        for (int i = 0; i < N; i++) begin
            a_arr[i] = AW'(i + 3);
            d_arr[i] = 32'hA000_0000 + 32'(i);
        end
        rst_n = 0; req_valid = 4'b1111; req_lock = '0; wb_stall = 0;

        // reset held with all requesters valid
        for (int c = 0; c < 3; c++) begin
            tick(g);
            check("rst_ready", {60'd0, obs_ready}, 64'd0);
            check("rst_en", {63'd0, wb_en}, 64'd0);
        end
        check("rst_outs", {wb_addr, wb_data, wb_src}, 64'd0);
        rst_n = 1;

        // plain round robin
        for (int c = 0; c < 8; c++) begin
            tick(g);
            expect_grant("rr", c % N);
            check("rr_en", {63'd0, wb_en}, 64'd1);
        end

        // wrap from pointer 3
        req_valid = 4'b0100; tick(g);
        req_valid = 4'b1001; tick(g); expect_grant("wrap3", 3);
        tick(g); expect_grant("wrap0", 0);
        req_valid = 4'b1111; tick(g); expect_grant("ptr_after_wrap", 1);

        // locked burst from requester 1, with one bubble
        req_valid = 4'b0001; tick(g);
        req_valid = 4'b1111; req_lock = 4'b0010;
        tick(g); expect_grant("lock_b0", 1);
        tick(g); expect_grant("lock_b1", 1);
        req_valid = 4'b1101; tick(g);
        check("lock_bubble", {60'd0, obs_ready}, 64'd0);
        check("lock_bubble_en", {63'd0, wb_en}, 64'd0);
        req_valid = 4'b1111; req_lock = 4'b0000;
        tick(g); expect_grant("lock_b2", 1);
        tick(g); expect_grant("lock_next", 2);

        // stall
        req_valid = 4'b0100; wb_stall = 1;
        for (int c = 0; c < 2; c++) begin
            tick(g);
            check("stall_ready", {60'd0, obs_ready}, 64'd0);
            check("stall_en", {63'd0, wb_en}, 64'd0);
        end
        wb_stall = 0;
        tick(g); expect_grant("post_stall", 2);
        check("post_stall_en", {63'd0, wb_en}, 64'd1);

        // reset while LOCKED(2)
        req_lock = 4'b0100; tick(g); expect_grant("lock2", 2);
        rst_n = 0; #1;
        model_reset();
        check("async_rst_en", {63'd0, wb_en}, 64'd0);
        tick(g);
        rst_n = 1; req_valid = 4'b1010; req_lock = '0;
        tick(g); expect_grant("after_rst", 1);

        // random traffic; beats stay valid until accepted
        pend = '0;
        req_valid = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    pend[i] = 1;
                    a_arr[i] = AW'($urandom);
                    d_arr[i] = $urandom;
                end
                req_lock[i] = ($urandom_range(0, 99) < 30);
            end
            wb_stall = ($urandom_range(0, 99) < 15);
            req_valid = pend;
            tick(g);
            if (g >= 0) pend[g] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
